// File: rtl/code_mem_arbiter.sv
// rtl/code_mem_arbiter.sv - single-port code RAM arbiter: boot loader writes, then CPU/debug reads
//
// Ports:
//   i_clk, i_nrst              clock, asynchronous active-low reset
//   i_reload                   synchronous pulse returning the block to BOOT
//   i_ld_req/addr/data/last    loader write request (last = final image byte)
//   o_ld_gnt                   loader write accepted this cycle
//   i_cpu_req/addr, o_cpu_gnt  CPU read request and same-cycle grant
//   o_cpu_rvalid/rdata         CPU read response, one cycle after grant
//   i_dbg_req/addr, o_dbg_gnt  debug read request and same-cycle grant
//   o_dbg_rvalid/rdata         debug read response, one cycle after grant
//   o_mem_wr/addr/wdata        RAM macro command
//   i_mem_rdata                RAM read data, one cycle after address
//   o_run                      boot complete, CPU may execute
module code_mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int MEM_DEPTH  = 512,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_reload,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_gnt,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_run
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(MEM_DEPTH);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic { BOOT, RUN } state_t;
  typedef enum logic [1:0] { OWN_NONE, OWN_CPU, OWN_DBG } owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [SW-1:0]    starve_q, starve_d;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= BOOT;
      owner_q  <= OWN_NONE;
      wr_cnt_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_cnt_q <= wr_cnt_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = OWN_NONE;
    wr_cnt_d    = wr_cnt_q;
    starve_d    = '0;
    o_ld_gnt    = 1'b0;
    o_cpu_gnt   = 1'b0;
    o_dbg_gnt   = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;

    case (state_q)
      BOOT: begin
        if (i_ld_req) begin
          o_ld_gnt    = 1'b1;
          o_mem_wr    = 1'b1;
          o_mem_addr  = i_ld_addr;
          o_mem_wdata = i_ld_data;
          // Saturate rather than wrap so a reloaded image cannot alias back to 0.
          if (wr_cnt_q != DEPTH_CNT) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (i_ld_last || (wr_cnt_q + CNT_W'(1) == DEPTH_CNT)) state_d = RUN;
        end
      end
      RUN: begin
        // Debug wins when the CPU is idle or when debug has been starved long enough.
        if (i_dbg_req && (!i_cpu_req || starve_q == STARVE_LIM)) begin
          o_dbg_gnt  = 1'b1;
          o_mem_addr = i_dbg_addr;
          owner_d    = OWN_DBG;
        end else if (i_cpu_req) begin
          o_cpu_gnt  = 1'b1;
          o_mem_addr = i_cpu_addr;
          owner_d    = OWN_CPU;
          // Debug lost a contested cycle; starve_q < STARVE_LIM here by construction.
          if (i_dbg_req) starve_d = starve_q + SW'(1);
        end
      end
      default: state_d = BOOT;
    endcase

    // Reload overrides any boot exit; a read granted this cycle still completes via owner_d.
    if (i_reload) begin
      state_d  = BOOT;
      wr_cnt_d = '0;
      starve_d = '0;
    end
  end

  assign o_run        = (state_q == RUN);
  assign o_cpu_rvalid = (owner_q == OWN_CPU);
  assign o_dbg_rvalid = (owner_q == OWN_DBG);
  assign o_cpu_rdata  = (owner_q == OWN_CPU) ? i_mem_rdata : '0;
  assign o_dbg_rdata  = (owner_q == OWN_DBG) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_code_mem_arbiter.sv
// tb/tb_code_mem_arbiter.sv - directed self-checking bench for code_mem_arbiter
module tb_code_mem_arbiter;

  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic       i_reload;
  logic       i_ld_req;
  logic [8:0] i_ld_addr;
  logic [7:0] i_ld_data;
  logic       i_ld_last;
  logic       o_ld_gnt;
  logic       i_cpu_req;
  logic [8:0] i_cpu_addr;
  logic       o_cpu_gnt;
  logic       o_cpu_rvalid;
  logic [7:0] o_cpu_rdata;
  logic       i_dbg_req;
  logic [8:0] i_dbg_addr;
  logic       o_dbg_gnt;
  logic       o_dbg_rvalid;
  logic [7:0] o_dbg_rdata;
  logic       o_mem_wr;
  logic [8:0] o_mem_addr;
  logic [7:0] o_mem_wdata;
  logic [7:0] i_mem_rdata;
  logic       o_run;

  logic       preload;
  logic [7:0] ram [0:511];

  int n_checks = 0;
  int n_fail   = 0;

  code_mem_arbiter #(
    .ADDR_W(9), .DATA_W(8), .MEM_DEPTH(512), .STARVE_MAX(4)
  ) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_reload(i_reload),
    .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .i_ld_last(i_ld_last), .o_ld_gnt(o_ld_gnt),
    .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr), .o_cpu_gnt(o_cpu_gnt),
    .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata),
    .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr), .o_dbg_gnt(o_dbg_gnt),
    .o_dbg_rvalid(o_dbg_rvalid), .o_dbg_rdata(o_dbg_rdata),
    .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_run(o_run)
  );

  always #5 i_clk = ~i_clk;

  // Single-port RAM: synchronous write, registered read data.
  always @(posedge i_clk) begin
    if (preload) begin
      ram[3] <= 8'hAA;
      ram[4] <= 8'hBB;
      ram[5] <= 8'h55;
      ram[6] <= 8'h66;
    end else if (o_mem_wr) begin
      ram[o_mem_addr] <= o_mem_wdata;
    end
    i_mem_rdata <= ram[o_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic dbg_prev;
    logic exp_dbg;

    i_nrst = 1'b0; i_reload = 1'b0; preload = 1'b1;
    i_ld_req = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_ld_last = 1'b0;
    i_cpu_req = 1'b0; i_cpu_addr = '0; i_dbg_req = 1'b0; i_dbg_addr = '0;
    #22;
    // Reset state
    check("rst_run", o_run, 0);
    check("rst_cpu_rvalid", o_cpu_rvalid, 0);
    check("rst_dbg_rvalid", o_dbg_rvalid, 0);
    check("rst_ld_gnt", o_ld_gnt, 0);
    check("rst_cpu_gnt", o_cpu_gnt, 0);
    check("rst_dbg_gnt", o_dbg_gnt, 0);
    check("rst_mem_wr", o_mem_wr, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_mem_wdata", o_mem_wdata, 0);
    check("rst_cpu_rdata", o_cpu_rdata, 0);
    i_nrst = 1'b1;
    preload = 1'b0;
    step();

    // Boot image of three bytes, CPU request held high throughout BOOT
    i_cpu_req = 1'b1; i_cpu_addr = 9'd0;
    for (int i = 0; i < 3; i++) begin
      i_ld_req  = 1'b1;
      i_ld_addr = 9'(i);
      i_ld_data = (i == 0) ? 8'h02 : (i == 1) ? 8'h00 : 8'h03;
      i_ld_last = (i == 2);
      #1;
      check("boot_ld_gnt", o_ld_gnt, 1);
      check("boot_mem_wr", o_mem_wr, 1);
      check("boot_mem_addr", o_mem_addr, i);
      check("boot_mem_wdata", o_mem_wdata, i_ld_data);
      check("boot_cpu_gnt", o_cpu_gnt, 0);
      check("boot_run", o_run, 0);
      step();
    end
    i_ld_req = 1'b0; i_ld_last = 1'b0;
    #1;
    check("boot_done_run", o_run, 1);
    check("run_cpu_gnt", o_cpu_gnt, 1);
    check("ram2", ram[2], 8'h03);
    i_cpu_req = 1'b0;
    step();

    // Back-to-back CPU reads; loader request ignored in RUN
    i_cpu_req = 1'b1; i_cpu_addr = 9'd3; i_ld_req = 1'b1; i_ld_addr = 9'd3; i_ld_data = 8'h11;
    #1;
    check("rd3_gnt", o_cpu_gnt, 1);
    check("rd3_addr", o_mem_addr, 3);
    check("rd3_mem_wr", o_mem_wr, 0);
    check("run_ld_gnt", o_ld_gnt, 0);
    step();
    i_cpu_addr = 9'd4;
    #1;
    check("rd4_gnt", o_cpu_gnt, 1);
    check("rd4_addr", o_mem_addr, 4);
    check("rd3_rvalid", o_cpu_rvalid, 1);
    check("rd3_rdata", o_cpu_rdata, 8'hAA);
    check("rd3_dbg_rvalid", o_dbg_rvalid, 0);
    check("rd3_dbg_rdata", o_dbg_rdata, 0);
    step();
    i_cpu_req = 1'b0; i_ld_req = 1'b0;
    #1;
    check("rd4_rvalid", o_cpu_rvalid, 1);
    check("rd4_rdata", o_cpu_rdata, 8'hBB);
    step();
    check("rd_idle_rvalid", o_cpu_rvalid, 0);
    check("rd_idle_rdata", o_cpu_rdata, 0);

    // Contention: CPU four cycles, debug on the fifth, repeating
    i_cpu_req = 1'b1; i_cpu_addr = 9'd5; i_dbg_req = 1'b1; i_dbg_addr = 9'd6;
    dbg_prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      exp_dbg = ((c % 5) == 4);
      #1;
      check("starve_cpu_gnt", o_cpu_gnt, !exp_dbg);
      check("starve_dbg_gnt", o_dbg_gnt, exp_dbg);
      check("starve_addr", o_mem_addr, exp_dbg ? 6 : 5);
      check("starve_dbg_rvalid", o_dbg_rvalid, dbg_prev);
      if (c > 0) begin
        check("starve_cpu_rvalid", o_cpu_rvalid, !dbg_prev);
        check("starve_rdata", dbg_prev ? o_dbg_rdata : o_cpu_rdata, dbg_prev ? 8'h66 : 8'h55);
      end
      dbg_prev = exp_dbg;
      step();
    end
    i_cpu_req = 1'b0; i_dbg_req = 1'b0;
    #1;
    check("starve_last_dbg_rvalid", o_dbg_rvalid, 1);
    check("starve_last_dbg_rdata", o_dbg_rdata, 8'h66);
    step();

    // CPU read granted in the reload cycle
    i_cpu_req = 1'b1; i_cpu_addr = 9'd3; i_reload = 1'b1;
    #1;
    check("rl_cpu_gnt", o_cpu_gnt, 1);
    check("rl_run_before", o_run, 1);
    step();
    i_reload = 1'b0;
    #1;
    check("rl_run_after", o_run, 0);
    check("rl_cpu_rvalid", o_cpu_rvalid, 1);
    check("rl_cpu_rdata", o_cpu_rdata, 8'hAA);
    check("rl_cpu_gnt_after", o_cpu_gnt, 0);
    step();
    check("rl_cpu_rvalid_gone", o_cpu_rvalid, 0);
    check("rl_cpu_gnt_gone", o_cpu_gnt, 0);
    i_cpu_req = 1'b0;

    // Last byte and reload together: write lands, stays in BOOT, counter cleared
    i_ld_req = 1'b1; i_ld_addr = 9'd7; i_ld_data = 8'h5A; i_ld_last = 1'b1; i_reload = 1'b1;
    #1;
    check("lr_ld_gnt", o_ld_gnt, 1);
    check("lr_mem_wr", o_mem_wr, 1);
    step();
    i_ld_req = 1'b0; i_ld_last = 1'b0; i_reload = 1'b0;
    #1;
    check("lr_run", o_run, 0);
    check("lr_ram7", ram[7], 8'h5A);

    // Full 512-byte image without last; run only after the 512th byte
    for (int i = 0; i < 512; i++) begin
      i_ld_req  = 1'b1;
      i_ld_addr = 9'(i);
      i_ld_data = 8'(i ^ 8'h3C);
      #1;
      check("full_ld_gnt", o_ld_gnt, 1);
      check("full_run_pending", o_run, 0);
      step();
    end
    i_ld_addr = 9'd0;
    #1;
    check("full_run", o_run, 1);
    check("extra_ld_gnt", o_ld_gnt, 0);
    check("extra_mem_wr", o_mem_wr, 0);
    i_ld_req = 1'b0;
    step();

    // Asynchronous reset drops a pending read response
    i_cpu_req = 1'b1; i_cpu_addr = 9'd4;
    step();
    i_cpu_req = 1'b0;
    #1;
    check("ar_rvalid_before", o_cpu_rvalid, 1);
    check("ar_rdata_before", o_cpu_rdata, 8'h38);
    i_nrst = 1'b0;
    #1;
    check("ar_rvalid_dropped", o_cpu_rvalid, 0);
    check("ar_run", o_run, 0);
    #2;
    i_nrst = 1'b1;
    step();
    check("ar_rvalid_after", o_cpu_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
